icache_req_arb: RTL

Arbiter and response router that shares the single ICache request port between the IFU demand stream and a next-line prefetcher. It sits between the IFU/prefetcher and the ICache. It grants one request per cycle with demand priority and bounded prefetch starvation. It records the owner of every in-flight request in an ordered owner FIFO, and steers each in-order ICache response back to the right requester. On a frontend flush it marks all outstanding responses to be dropped, so stale lines never reach the IFU.

---
 rtl/icache_req_arb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/icache_req_arb.sv
// icache_req_arb
//   Shares the single ICache request port between the IFU demand stream and a
//   next-line prefetcher. Demand has priority; the prefetcher is forced through
//   after STARVE_LIMIT consecutive cycles in which it lost to a demand grant.
//   Every accepted request records its owner in a circular owner FIFO. The
//   in-order ICache responses are steered back to the owner. A flush marks
//   every outstanding entry as drop, so stale lines never reach the IFU.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  frontend flush/redirect: no grant, drop outstanding
//   dmd_req_*                demand request (valid/ready/addr)
//   pf_req_*                 prefetch request (valid/ready/addr)
//   ic_req_*                 request to the ICache (valid/ready/addr)
//   ic_rsp_valid_i/data_i    in-order ICache response, no backpressure
//   dmd_rsp_valid_o/data_o   response delivered to the demand side
//   pf_rsp_valid_o           prefetch completion pulse
//   inflight_cnt_o           owner FIFO occupancy
//   proto_err_o              sticky: response arrived with no request outstanding
module icache_req_arb #(
  parameter int VLEN            = 32,
  parameter int ILEN            = 32,
  parameter int INSTR_PER_FETCH = 4,
  parameter int INF_DEPTH       = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              dmd_req_valid_i,
  output logic                              dmd_req_ready_o,
  input  logic [VLEN-1:0]                   dmd_req_addr_i,
  input  logic                              pf_req_valid_i,
  output logic                              pf_req_ready_o,
  input  logic [VLEN-1:0]                   pf_req_addr_i,
  output logic                              ic_req_valid_o,
  input  logic                              ic_req_ready_i,
  output logic [VLEN-1:0]                   ic_req_addr_o,
  input  logic                              ic_rsp_valid_i,
  input  logic [INSTR_PER_FETCH*ILEN-1:0]   ic_rsp_data_i,
  output logic                              dmd_rsp_valid_o,
  output logic [INSTR_PER_FETCH*ILEN-1:0]   dmd_rsp_data_o,
  output logic                              pf_rsp_valid_o,
  output logic [$clog2(INF_DEPTH+1)-1:0]    inflight_cnt_o,
  output logic                              proto_err_o
);

  localparam int PTR_W = (INF_DEPTH > 1) ? $clog2(INF_DEPTH) : 1;
  localparam int CNT_W = $clog2(INF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(INF_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(INF_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);

  // Owner FIFO storage: owner 0 = demand, 1 = prefetch.
  logic [INF_DEPTH-1:0] owner_q;
  logic [INF_DEPTH-1:0] drop_q;
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [STV_W-1:0]     starve_q;
  logic                 proto_err_q;

  logic pop;
  logic space;
  logic issue_ok;
  logic force_pf;
  logic pf_win;
  logic fire;
  logic head_owner;
  logic head_drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Arbitration and response routing: purely combinational.
  assign pop      = ic_rsp_valid_i && (cnt_q != '0);
  // A pop in this cycle frees a slot, so a full FIFO can still accept.
  assign space    = (cnt_q < DEPTH_CNT) || pop;
  assign issue_ok = !flush_i && space;
  assign force_pf = (starve_q == STV_MAX);
  assign pf_win   = pf_req_valid_i && (force_pf || !dmd_req_valid_i);

  assign ic_req_valid_o  = issue_ok && (dmd_req_valid_i || pf_req_valid_i);
  assign ic_req_addr_o   = pf_win ? pf_req_addr_i : dmd_req_addr_i;
  assign dmd_req_ready_o = issue_ok && ic_req_ready_i && !pf_win;
  assign pf_req_ready_o  = issue_ok && ic_req_ready_i && pf_win;
  assign fire            = ic_req_valid_o && ic_req_ready_i;

  assign head_owner = owner_q[head_q];
  assign head_drop  = drop_q[head_q];

  // The response popped during a flush is stale as well, so it is suppressed.
  assign dmd_rsp_valid_o = pop && !flush_i && !head_drop && !head_owner;
  assign pf_rsp_valid_o  = pop && !flush_i && !head_drop && head_owner;
  assign dmd_rsp_data_o  = ic_rsp_data_i;
  assign inflight_cnt_o  = cnt_q;
  assign proto_err_o     = proto_err_q;

  // Control state: pointers, occupancy, starvation counter, error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (fire) begin
        tail_q <= ptr_inc(tail_q);
      end
      case ({fire, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (flush_i || !pf_req_valid_i || (fire && pf_win)) begin
        starve_q <= '0;
      end else if (fire && !pf_win && (starve_q != STV_MAX)) begin
        starve_q <= starve_q + STV_W'(1);
      end

      if (ic_rsp_valid_i && (cnt_q == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Entry payload: only meaningful while counted in cnt_q, so no reset.
  // Flush never coincides with a push, so the two updates are independent.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      drop_q <= '1;
    end
    if (fire) begin
      owner_q[tail_q] <= pf_win;
      drop_q[tail_q]  <= 1'b0;
    end
  end

endmodule
